// File: rtl/inst_mem_arbiter.sv
// rtl/inst_mem_arbiter.sv - round-robin fetch/loader arbiter in front of the single-port instruction RAM
module inst_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] f_address,
    input  logic              f_read,
    output logic              f_waitrequest,
    output logic [DATA_W-1:0] f_readdata,
    output logic              f_readdatavalid,

    input  logic [ADDR_W-1:0] l_address,
    input  logic              l_read,
    input  logic              l_write,
    input  logic [DATA_W-1:0] l_writedata,
    input  logic [BE_W-1:0]   l_byteenable,
    output logic              l_waitrequest,
    output logic [DATA_W-1:0] l_readdata,
    output logic              l_readdatavalid,

    input  logic              hold_req,
    output logic              hold_ack,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // Owner encoding for last/rd_owner: 1 = loader, 0 = fetch.
    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   rd_valid_q, rd_valid_d;
    logic   rd_owner_q, rd_owner_d;

    logic   f_elig;
    logic   l_elig;
    logic   grant_f;
    logic   grant_l;
    logic   fetch_outstanding;

    // Grants are gated by reset_n so the RAM sees no access while reset is asserted.
    always_comb begin
        l_elig  = l_read | l_write;
        f_elig  = f_read & (state_q == ST_RUN) & ~hold_req;
        grant_f = reset_n & f_elig & (~l_elig | last_q);
        grant_l = reset_n & l_elig & (~f_elig | ~last_q);
        fetch_outstanding = rd_valid_q & ~rd_owner_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            last_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // With no fetch read in flight the quiesce completes straight from RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hold_req) begin
                    state_d = fetch_outstanding ? ST_DRAIN : ST_HELD;
                end
            end
            ST_DRAIN: begin
                if (!hold_req) begin
                    state_d = ST_RUN;
                end else if (!fetch_outstanding) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!hold_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (grant_l) begin
            last_d = 1'b1;
        end else if (grant_f) begin
            last_d = 1'b0;
        end
        rd_valid_d = grant_f | (grant_l & ~l_write);
        rd_owner_d = grant_l;
    end

    always_comb begin
        hold_ack        = (state_q == ST_HELD);
        f_waitrequest   = ~grant_f;
        l_waitrequest   = ~grant_l;
        f_readdata      = mem_readdata;
        l_readdata      = mem_readdata;
        f_readdatavalid = rd_valid_q & ~rd_owner_q;
        l_readdatavalid = rd_valid_q & rd_owner_q;

        mem_chipselect  = grant_f | grant_l;
        mem_address     = grant_l ? l_address : f_address;
        mem_byteenable  = grant_l ? l_byteenable : {BE_W{1'b1}};
        mem_write       = grant_l & l_write;
        mem_writedata   = l_writedata;
        mem_clken       = reset_n;
    end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// tb/tb_inst_mem_arbiter.sv - directed self-checking bench for inst_mem_arbiter
module tb_inst_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] f_address;
    logic        f_read;
    logic        f_waitrequest;
    logic [31:0] f_readdata;
    logic        f_readdatavalid;
    logic [12:0] l_address;
    logic        l_read;
    logic        l_write;
    logic [31:0] l_writedata;
    logic [3:0]  l_byteenable;
    logic        l_waitrequest;
    logic [31:0] l_readdata;
    logic        l_readdatavalid;
    logic        hold_req;
    logic        hold_ack;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    int checks = 0;
    int passes = 0;
    int fc;
    int lc;

    logic [31:0] ram [0:8191];

    always #5 clk = ~clk;

    inst_mem_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .f_address       (f_address),
        .f_read          (f_read),
        .f_waitrequest   (f_waitrequest),
        .f_readdata      (f_readdata),
        .f_readdatavalid (f_readdatavalid),
        .l_address       (l_address),
        .l_read          (l_read),
        .l_write         (l_write),
        .l_writedata     (l_writedata),
        .l_byteenable    (l_byteenable),
        .l_waitrequest   (l_waitrequest),
        .l_readdata      (l_readdata),
        .l_readdatavalid (l_readdatavalid),
        .hold_req        (hold_req),
        .hold_ack        (hold_ack),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata)
    );

    // Single-port RAM with byte enables and one-cycle read latency.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic lwr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        l_write = 1'b1;
        l_address = a;
        l_writedata = d;
        l_byteenable = be;
        @(negedge clk);
        l_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        f_address = '0; f_read = 1'b1;
        l_address = '0; l_read = 1'b0; l_write = 1'b1;
        l_writedata = '0; l_byteenable = 4'hF; hold_req = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk1("rst_f_wait", f_waitrequest, 1'b1);
        chk1("rst_l_wait", l_waitrequest, 1'b1);
        chk1("rst_cs", mem_chipselect, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_clken", mem_clken, 1'b0);
        chk1("rst_f_rdv", f_readdatavalid, 1'b0);
        chk1("rst_l_rdv", l_readdatavalid, 1'b0);
        chk1("rst_hold_ack", hold_ack, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1; f_read = 1'b0; l_write = 1'b0;
        @(negedge clk);
        #1 chk1("run_clken", mem_clken, 1'b1);

        lwr(13'h0010, 32'hDEADBEEF, 4'hF);
        lwr(13'h1FFF, 32'hAAAAAAAA, 4'hF);
        for (int k = 0; k < 4; k++) begin
            lwr(13'h100 + 13'(k), 32'hF0000000 + 32'(k), 4'hF);
            lwr(13'h200 + 13'(k), 32'hA0000000 + 32'(k), 4'hF);
        end

        // Single uncontended fetch read
        @(negedge clk);
        f_read = 1'b1; f_address = 13'h0010;
        #1;
        chk1("sf_wait", f_waitrequest, 1'b0);
        chk1("sf_l_wait", l_waitrequest, 1'b1);
        chk1("sf_cs", mem_chipselect, 1'b1);
        chk32("sf_addr", 32'(mem_address), 32'h10);
        chk32("sf_be", 32'(mem_byteenable), 32'hF);
        chk1("sf_write", mem_write, 1'b0);
        @(negedge clk);
        f_read = 1'b0;
        #1;
        chk1("sf_rdv", f_readdatavalid, 1'b1);
        chk32("sf_data", f_readdata, 32'hDEADBEEF);
        chk1("sf_l_rdv", l_readdatavalid, 1'b0);

        // Byte-enabled write then immediate read of the same word
        @(negedge clk);
        l_write = 1'b1; l_address = 13'h1FFF; l_writedata = 32'h11223344; l_byteenable = 4'b0101;
        #1;
        chk1("bw_wait", l_waitrequest, 1'b0);
        chk1("bw_write", mem_write, 1'b1);
        chk32("bw_be", 32'(mem_byteenable), 32'h5);
        chk32("bw_wdata", mem_writedata, 32'h11223344);
        @(negedge clk);
        l_write = 1'b0; l_read = 1'b1;
        #1;
        chk1("br_wait", l_waitrequest, 1'b0);
        chk1("bw_no_rdv", l_readdatavalid, 1'b0);
        @(negedge clk);
        l_read = 1'b0;
        #1;
        chk1("br_rdv", l_readdatavalid, 1'b1);
        chk32("br_data", l_readdata, 32'hAA22AA44);
        chk1("br_f_rdv", f_readdatavalid, 1'b0);

        // Both masters reading every cycle: grants alternate starting with fetch
        fc = 0; lc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            f_read = 1'b1; f_address = 13'h100 + 13'(fc);
            l_read = 1'b1; l_address = 13'h200 + 13'(lc);
            #1;
            chk1("ct_f_wait", f_waitrequest, (i % 2) == 1);
            chk1("ct_l_wait", l_waitrequest, (i % 2) == 0);
            if (i > 0) begin
                if (i % 2 == 1) begin
                    chk1("ct_f_rdv", f_readdatavalid, 1'b1);
                    chk1("ct_l_rdv0", l_readdatavalid, 1'b0);
                    chk32("ct_f_data", f_readdata, 32'hF0000000 + 32'((i - 1) / 2));
                end else begin
                    chk1("ct_l_rdv", l_readdatavalid, 1'b1);
                    chk1("ct_f_rdv0", f_readdatavalid, 1'b0);
                    chk32("ct_l_data", l_readdata, 32'hA0000000 + 32'((i - 2) / 2));
                end
            end
            if (i % 2 == 0) fc++;
            else lc++;
        end
        @(negedge clk);
        f_read = 1'b0; l_read = 1'b0;
        #1;
        chk1("ct_last_rdv", l_readdatavalid, 1'b1);
        chk32("ct_last_data", l_readdata, 32'hA0000003);

        // Hold with a fetch read in flight when hold_req rises
        @(negedge clk);
        f_read = 1'b1; f_address = 13'h0010;
        #1 chk1("h0_f_wait", f_waitrequest, 1'b0);
        @(negedge clk);
        hold_req = 1'b1;
        #1;
        chk1("h1_f_blocked", f_waitrequest, 1'b1);
        chk1("h1_ack", hold_ack, 1'b0);
        chk1("h1_f_rdv", f_readdatavalid, 1'b1);
        @(negedge clk);
        #1;
        chk1("h2_ack", hold_ack, 1'b0);
        chk1("h2_f_blocked", f_waitrequest, 1'b1);
        @(negedge clk);
        l_read = 1'b1; l_address = 13'h0010;
        #1;
        chk1("h3_ack", hold_ack, 1'b1);
        chk1("h3_l_wait", l_waitrequest, 1'b0);
        @(negedge clk);
        l_read = 1'b0; hold_req = 1'b0;
        #1;
        chk1("h4_ack", hold_ack, 1'b1);
        chk1("h4_l_rdv", l_readdatavalid, 1'b1);
        chk32("h4_l_data", l_readdata, 32'hDEADBEEF);
        chk1("h4_f_blocked", f_waitrequest, 1'b1);
        @(negedge clk);
        #1;
        chk1("h5_ack", hold_ack, 1'b0);
        chk1("h5_f_wait", f_waitrequest, 1'b0);

        // Hold with nothing outstanding acknowledges after one cycle
        @(negedge clk);
        f_read = 1'b0;
        @(negedge clk);
        hold_req = 1'b1;
        #1 chk1("hf_ack0", hold_ack, 1'b0);
        @(negedge clk);
        #1 chk1("hf_ack1", hold_ack, 1'b1);
        @(negedge clk);
        hold_req = 1'b0;
        @(negedge clk);
        #1 chk1("hf_ack_fall", hold_ack, 1'b0);

        // One-cycle hold pulse while draining aborts back to RUN
        @(negedge clk);
        f_read = 1'b1; f_address = 13'h0010;
        #1 chk1("ab_f_wait", f_waitrequest, 1'b0);
        @(negedge clk);
        f_read = 1'b0; hold_req = 1'b1;
        @(negedge clk);
        hold_req = 1'b0;
        #1 chk1("ab_ack_a", hold_ack, 1'b0);
        @(negedge clk);
        #1 chk1("ab_ack_b", hold_ack, 1'b0);
        @(negedge clk);
        #1 chk1("ab_ack_c", hold_ack, 1'b0);
        @(negedge clk);
        f_read = 1'b1;
        #1 chk1("ab_run", f_waitrequest, 1'b0);

        // Reset while that fetch read is outstanding
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk1("mr_f_rdv", f_readdatavalid, 1'b0);
        chk1("mr_f_wait", f_waitrequest, 1'b1);
        chk1("mr_cs", mem_chipselect, 1'b0);
        chk1("mr_clken", mem_clken, 1'b0);
        @(negedge clk);
        reset_n = 1'b1; f_read = 1'b0;
        #1;
        chk1("mr_post_f_rdv", f_readdatavalid, 1'b0);
        chk1("mr_post_l_rdv", l_readdatavalid, 1'b0);
        @(negedge clk);
        f_read = 1'b1; l_read = 1'b1; f_address = 13'h0010; l_address = 13'h0100;
        #1;
        chk1("mr_last_f", f_waitrequest, 1'b0);
        chk1("mr_last_l", l_waitrequest, 1'b1);
        @(negedge clk);
        f_read = 1'b0; l_read = 1'b0;
        #1;
        chk1("mr_f_rdv2", f_readdatavalid, 1'b1);
        chk32("mr_f_data", f_readdata, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
